// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch path: owns the PC, handshakes fetches with imem,
// and selects sequential/branch/jump/JR/exception targets. Build option: PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        exception,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        addr_err
);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

    state_t      state, state_next;
    logic [31:0] pc_next;
    logic        take_exc;
    logic        pc_update;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign pc_update = (state == EXEC) && !stall;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = EXEC;
            EXEC:    if (!stall) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH:   imem_req    = 1'b1;
            EXEC:    instr_valid = 1'b1;
            default: ;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic jr_misaligned;
    assign jr_misaligned = !exception && jump_reg && (jr_target[1:0] != 2'b00);
`endif

    // Next-PC select; exception and misaligned JR share the vector path
    always_comb begin
        take_exc = 1'b0;
        pc_next  = pc_plus4;
        if (exception) begin
            take_exc = 1'b1;
        end else if (jump_reg) begin
`ifdef PC_ALIGN_CHECK_EN
            if (jr_misaligned) take_exc = 1'b1;
            else               pc_next  = jr_target;
`else
            pc_next = {jr_target[31:2], 2'b00};
`endif
        end else if (jump) begin
            pc_next = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4 + {branch_offset[29:0], 2'b00};
        end
        if (take_exc) pc_next = EXC_VECTOR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= RESET_ADDR;
            epc <= 32'h0;
        end else if (pc_update) begin
            pc <= pc_next;
            if (take_exc) epc <= pc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Pulse lands in the FETCH cycle that follows the faulting EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) addr_err <= 1'b0;
        else       addr_err <= pc_update && jr_misaligned;
    end
`else
    assign addr_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{branch_offset[31:30], jr_target[1:0]};

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued when the EXEC
// decision is driven and popped when the DUT presents the next fetch.
module tb_pc_sequencer;

    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        exception = 1'b0;
    logic [31:0] pc, pc_plus4, epc;
    logic        addr_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc  = 32'h0;
    logic [31:0] model_epc = 32'h0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .jr_target(jr_target),
        .exception(exception),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present the fetch, optionally stretch it with wait cycles, then ack into EXEC
    task automatic do_fetch(input int waits);
        logic [31:0] exp;
        int n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'h0, imem_req}, 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("fetch_addr", imem_addr, exp);
        chk("fetch_valid", {31'h0, instr_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", {31'h0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("exec_valid", {31'h0, instr_valid}, 32'd1);
        chk("exec_req", {31'h0, imem_req}, 32'd0);
        chk("exec_addr_err", {31'h0, addr_err}, 32'd0);
        chk("pc_plus4", pc_plus4, exp + 32'd4);
    endtask

    // Drive the EXEC-cycle inputs, predict the redirect, and hold stall for `stalls` cycles first
    task automatic do_exec(input int stalls, input logic exc, input logic jr, input logic [31:0] jrt,
                           input logic j, input logic [25:0] jidx,
                           input logic br, input logic [31:0] boff);
        logic [31:0] p4, npc;
        logic        aerr;
        p4   = model_pc + 32'd4;
        aerr = 1'b0;
        npc  = p4;
        if (exc) begin
            model_epc = model_pc;
            npc = EXC_VEC;
        end else if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
            if (jrt[1:0] != 2'b00) begin
                model_epc = model_pc;
                npc  = EXC_VEC;
                aerr = 1'b1;
            end else npc = jrt;
`else
            npc = {jrt[31:2], 2'b00};
`endif
        end else if (j) begin
            npc = {p4[31:28], jidx, 2'b00};
        end else if (br) begin
            npc = p4 + {boff[29:0], 2'b00};
        end
        exception = exc; jump_reg = jr; jr_target = jrt;
        jump = j; jump_index = jidx; branch_taken = br; branch_offset = boff;
        stall = (stalls > 0);
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, model_pc);
            chk("stall_valid", {31'h0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        exception = 1'b0; jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        exp_q.push_back(npc);
        model_pc = npc;
        chk("epc", epc, model_epc);
        chk("addr_err", {31'h0, addr_err}, {31'h0, aerr});
    endtask

    initial begin
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_rise", {31'h0, imem_req}, 32'd1);
        exp_q.push_back(32'h0);

        // Sequential fetch 0x0, 0x4, 0x8 with zero-wait memory
        do_fetch(0); do_exec(0, 0, 0, 0, 0, 0, 0, 0);
        do_fetch(0); do_exec(0, 0, 0, 0, 0, 0, 0, 0);
        do_fetch(0); do_exec(0, 0, 0, 0, 1, 26'h40, 0, 0);          // jump to 0x100
        do_fetch(1); do_exec(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);   // back branch to 0xFC
        do_fetch(0); do_exec(0, 0, 1, 32'h1000_0040, 0, 0, 0, 0);
        do_fetch(2); do_exec(0, 0, 0, 0, 1, 26'h40, 1, 32'h5);      // jump beats branch
        do_fetch(0); do_exec(0, 0, 1, 32'h0000_0020, 0, 0, 0, 0);
        do_fetch(0); do_exec(0, 1, 1, 32'h0000_0300, 0, 0, 0, 0);   // exception beats JR
        do_fetch(0); do_exec(3, 0, 0, 0, 1, 26'h3FF, 0, 0);         // stall holds PC
        do_fetch(0); do_exec(0, 0, 1, 32'h0000_0206, 0, 0, 0, 0);   // misaligned JR
        do_fetch(0); do_exec(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        do_fetch(0); do_exec(0, 0, 0, 0, 0, 0, 0, 0);               // wraps to 0
        do_fetch(0); do_exec(0, 0, 0, 0, 1, 26'h10, 0, 0);          // jump to 0x40

        // Long wait then reset mid-FETCH with a late ack
        chk("pre_rst_addr", imem_addr, exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("long_wait_req", {31'h0, imem_req}, 32'd1);
        end
        reset = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_pc_plus4", pc_plus4, 32'h4);
        chk("mid_rst_req", {31'h0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("mid_rst_epc", epc, 32'h0);
        @(negedge clk);
        chk("rst_hold_valid", {31'h0, instr_valid}, 32'd0);
        reset = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'h0, imem_req}, 32'd1);
        chk("post_rst_valid", {31'h0, instr_valid}, 32'd0);
        model_pc = 32'h0;
        model_epc = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        do_fetch(0); do_exec(0, 0, 0, 0, 0, 0, 0, 0);
        do_fetch(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the MIPS fetch path. Owns the program counter register, sequences instruction-memory fetches with a request/acknowledge handshake, and selects the next PC from sequential, branch, jump, jump-register and exception sources. Sits between the instruction memory and decode; the PC register and adder are internal, so decode sees only `pc`/`pc_plus4` and a valid strobe.

## Interface
- `RESET_ADDR`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0080, PC value loaded on exception or address error.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_ack`  in  1  instruction memory accepts or returns the fetch at `imem_addr`.
- `instr_valid`  out  1  fetched instruction is valid for decode (EXEC state).
- `stall`  in  1  decode hold; freezes PC in EXEC.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_offset`  in  32  sign-extended word offset.
- `jump`  in  1  J/JAL redirect.
- `jump_index`  in  26  J-type target index.
- `jump_reg`  in  1  JR/JALR redirect.
- `jr_target`  in  32  register target for `jump_reg`.
- `exception`  in  1  exception request.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4` mod 2^32 (link value).
- `epc`  out  32  PC of the instruction that raised the exception.
- `addr_err`  out  1  one-cycle pulse on misaligned JR target (see Configuration).

## Operation
- FSM states: BOOT, FETCH, EXEC.
- BOOT: `imem_req`=0, `instr_valid`=0; always moves to FETCH on the next edge.
- FETCH: `imem_req`=1. If `imem_ack`=1 -> EXEC; otherwise stay. `stall` and all redirect inputs are ignored in FETCH.
- EXEC: `instr_valid`=1, `imem_req`=0. If `stall`=1: stay in EXEC and hold PC; redirect inputs are ignored. If `stall`=0: update PC, then -> FETCH.
- Next-PC priority in EXEC (highest first):
  1. `exception`: `epc`<=`pc`; `pc`<=`EXC_VECTOR`.
  2. `jump_reg`: `pc`<=`jr_target`; alignment handling per Configuration.
  3. `jump`: `pc`<={`pc_plus4`[31:28], `jump_index`, 2'b00}.
  4. `branch_taken`: `pc`<=`pc_plus4` + {`branch_offset`[29:0], 2'b00}, mod 2^32.
  5. Otherwise: `pc`<=`pc_plus4`.
- All arithmetic is 32-bit and wraps. 0xFFFF_FFFC sequentially becomes 0x0000_0000.
- `epc` changes only on an exception or address error.
- Reset, asserted at any time including mid-handshake, forces the reset values immediately. Any pending ack is discarded.

## Timing
- Reset values: state=BOOT, `pc`=`RESET_ADDR`, `pc_plus4`=`RESET_ADDR`+4, `imem_req`=0, `instr_valid`=0, `epc`=0, `addr_err`=0.
- The first edge after reset deasserts -> FETCH. `imem_req` rises one cycle after reset release.
- `imem_ack` is sampled on the edge. With zero-wait memory, each instruction takes 2 cycles (FETCH + EXEC). Each wait cycle adds one FETCH cycle.
- A redirect sampled in EXEC is visible on `pc`/`imem_addr` in the following FETCH cycle.
- State, `pc`, `epc` and `addr_err` are registered outputs. `imem_addr` is a wire from `pc`.

## Configuration
- `PC_ALIGN_CHECK_EN` defined: if `jump_reg` wins and `jr_target`[1:0]≠0, the redirect is treated as an exception: `epc`<=`pc`, `pc`<=`EXC_VECTOR`, and `addr_err` pulses for one cycle, coincident with the next FETCH.
- Not defined: `jr_target`[1:0] is forced to 2'b00, and `addr_err` is tied to 0.

## Test plan
- Reset release with `imem_ack`=1 constant -> `pc` sequence 0x0, 0x4, 0x8, with `instr_valid` high every second cycle and `imem_req` low during BOOT.
- `pc`=0x100, `branch_taken`=1, `branch_offset`=32'hFFFF_FFFE in EXEC -> next FETCH `imem_addr`=0xFC.
- `pc`=0x1000_0040, `jump`=1, `jump_index`=26'h40, `branch_taken`=1 simultaneously -> `pc`=0x1000_0100 (jump beats branch).
- `exception`=1 together with `jump_reg`=1 at `pc`=0x20 -> `pc`=0x80, `epc`=0x20. Then hold `stall`=1 for 3 cycles -> `pc` is frozen and `instr_valid` stays high.
- `jr_target`=0x0000_0206 -> with `PC_ALIGN_CHECK_EN`: `pc`=0x80, `addr_err` pulses once; without it: `pc`=0x204.
- `imem_ack` held low for 4 cycles, then `reset` asserted mid-FETCH -> outputs return to reset values immediately, and the late ack is ignored.
